// File: rtl/sram_arbiter_2x1.sv
// Two-master arbiter sharing one single-port SRAM between instruction (m0) and data (m1) ports.
// Define SRAM_ARB_RR_EN for round-robin conflict resolution; default is fixed priority to m1.
module sram_arbiter_2x1 #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic [3:0]        m0_wen,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic [3:0]        m1_wen,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              sram_en,
  output logic [3:0]        sram_wen,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic [CNT_W-1:0]  conflict_cnt
);

  logic              both_req;
  logic              conf_win1;
  logic              rd_vld;
  logic              rd_id;
  logic              rd_accept;
  logic [DATA_W-1:0] m0_hold;
  logic [DATA_W-1:0] m1_hold;

  assign both_req = m0_req & m1_req;

`ifdef SRAM_ARB_RR_EN
  // Last conflict winner; cleared so the first conflict after reset goes to m1.
  logic rr_last;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        rr_last <= 1'b0;
    else if (both_req) rr_last <= ~rr_last;
  end

  assign conf_win1 = ~rr_last;
`else
  assign conf_win1 = 1'b1;
`endif

  assign m0_gnt = reset & m0_req & (~m1_req | ~conf_win1);
  assign m1_gnt = reset & m1_req & (~m0_req |  conf_win1);

  always_comb begin
    sram_en    = 1'b0;
    sram_wen   = 4'b0;
    sram_addr  = '0;
    sram_wdata = '0;
    if (m1_gnt) begin
      sram_en    = 1'b1;
      sram_wen   = m1_wen;
      sram_addr  = m1_addr;
      sram_wdata = m1_wdata;
    end else if (m0_gnt) begin
      sram_en    = 1'b1;
      sram_wen   = m0_wen;
      sram_addr  = m0_addr;
      sram_wdata = m0_wdata;
    end
  end

  assign rd_accept = (m0_gnt & (m0_wen == 4'b0)) | (m1_gnt & (m1_wen == 4'b0));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_vld <= 1'b0;
      rd_id  <= 1'b0;
    end else begin
      rd_vld <= rd_accept;
      rd_id  <= m1_gnt;
    end
  end

  assign m0_rvalid = rd_vld & ~rd_id;
  assign m1_rvalid = rd_vld &  rd_id;

  // SRAM data flows straight through on the return cycle; hold regs keep it afterwards.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m0_hold <= '0;
      m1_hold <= '0;
    end else begin
      if (m0_rvalid) m0_hold <= sram_rdata;
      if (m1_rvalid) m1_hold <= sram_rdata;
    end
  end

  assign m0_rdata = m0_rvalid ? sram_rdata : m0_hold;
  assign m1_rdata = m1_rvalid ? sram_rdata : m1_hold;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      conflict_cnt <= '0;
    else if (both_req && (conflict_cnt != {CNT_W{1'b1}}))
      conflict_cnt <= conflict_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
  end

endmodule

// File: tb/tb_sram_arbiter_2x1.sv
// Bench for sram_arbiter_2x1: directed vector table, random traffic against a transaction model,
// reset-with-pending-read and counter saturation sequences. Honors SRAM_ARB_RR_EN.
module tb_sram_arbiter_2x1;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int CW = 16;
  localparam logic [31:0] DE = 32'hDEADBEEF;
  localparam logic [31:0] CC = 32'h12345678;

  logic          clk = 1'b0;
  logic          reset;
  logic          m0_req, m1_req;
  logic [3:0]    m0_wen, m1_wen;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          sram_en;
  logic [3:0]    sram_wen;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_wdata, sram_rdata;
  logic [CW-1:0] conflict_cnt;

  sram_arbiter_2x1 #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_wen(m0_wen), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_wen(m1_wen), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .sram_en(sram_en), .sram_wen(sram_wen), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .conflict_cnt(conflict_cnt)
  );

  always #5 clk = ~clk;

  // SRAM slave: 4096 words, one-cycle read latency, byte-enabled writes.
  bit [31:0] smem [4096];
  bit [31:0] srd;
  bit        preload;
  always @(posedge clk) begin
    if (preload) smem[16] <= DE;
    else if (sram_en) begin
      if (sram_wen == 4'b0) srd <= smem[sram_addr[13:2]];
      else for (int b = 0; b < 4; b++)
        if (sram_wen[b]) smem[sram_addr[13:2]][8*b +: 8] <= sram_wdata[8*b +: 8];
    end
  end
  assign sram_rdata = srd;

  // Transaction-level reference model.
  bit [31:0]   mmem [4096];
  bit          p_vld, p_id;
  bit [31:0]   p_data;
  bit [31:0]   hold [2];
  int unsigned mcnt;
`ifdef SRAM_ARB_RR_EN
  int          rr_next;
`endif

  int   checks = 0, failures = 0;
  logic s_g0, s_g1, s_v0, s_v1;
  logic [31:0] s_sa, s_rd0, s_rd1;

  typedef struct packed {
    logic r0; logic [3:0] w0; logic [31:0] a0, d0;
    logic r1; logic [3:0] w1; logic [31:0] a1, d1;
    logic g0, g1, v0, v1;
    logic [31:0] sa, rd0, rd1;
  } vec_t;

  function automatic vec_t mk(logic r0, logic [31:0] a0, logic [3:0] w0, logic [31:0] d0,
                              logic r1, logic [31:0] a1, logic [3:0] w1, logic [31:0] d1,
                              logic g0, logic g1, logic v0, logic v1,
                              logic [31:0] sa, logic [31:0] rd0, logic [31:0] rd1);
    vec_t v;
    v.r0 = r0; v.a0 = a0; v.w0 = w0; v.d0 = d0;
    v.r1 = r1; v.a1 = a1; v.w1 = w1; v.d1 = d1;
    v.g0 = g0; v.g1 = g1; v.v0 = v0; v.v1 = v1;
    v.sa = sa; v.rd0 = rd0; v.rd1 = rd1;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    p_vld = 0; p_id = 0; p_data = 0;
    hold[0] = 0; hold[1] = 0; mcnt = 0;
`ifdef SRAM_ARB_RR_EN
    rr_next = 1;
`endif
  endtask

  // One clock cycle: entered and left at posedge+1.
  task automatic step(input logic r0, input logic [3:0] w0, input logic [31:0] a0, input logic [31:0] d0,
                      input logic r1, input logic [3:0] w1, input logic [31:0] a1, input logic [31:0] d1,
                      input bit ce);
    int win;
    logic [3:0]  ew;
    logic [31:0] ea, ed, erd0, erd1;
    bit ev0, ev1;
    m0_req = r0; m0_wen = w0; m0_addr = a0; m0_wdata = d0;
    m1_req = r1; m1_wen = w1; m1_addr = a1; m1_wdata = d1;
    win = -1;
    if (r0 && r1) begin
`ifdef SRAM_ARB_RR_EN
      win = rr_next;
`else
      win = 1;
`endif
    end else if (r0) win = 0;
    else if (r1) win = 1;
    ew = (win == 0) ? w0 : (win == 1) ? w1 : 4'b0;
    ea = (win == 0) ? a0 : (win == 1) ? a1 : 32'h0;
    ed = (win == 0) ? d0 : (win == 1) ? d1 : 32'h0;
    ev0 = p_vld && !p_id;
    ev1 = p_vld && p_id;
    erd0 = ev0 ? p_data : hold[0];
    erd1 = ev1 ? p_data : hold[1];
    #3;
    s_g0 = m0_gnt; s_g1 = m1_gnt; s_v0 = m0_rvalid; s_v1 = m1_rvalid;
    s_sa = sram_addr; s_rd0 = m0_rdata; s_rd1 = m1_rdata;
    if (ce) begin
      chk("m0_gnt", m0_gnt, win == 0);
      chk("m1_gnt", m1_gnt, win == 1);
      chk("sram_en", sram_en, win >= 0);
      chk("sram_wen", sram_wen, ew);
      chk("sram_addr", sram_addr, ea);
      chk("sram_wdata", sram_wdata, ed);
      chk("m0_rvalid", m0_rvalid, ev0);
      chk("m1_rvalid", m1_rvalid, ev1);
      chk("m0_rdata", m0_rdata, erd0);
      chk("m1_rdata", m1_rdata, erd1);
      chk("conflict_cnt", conflict_cnt, mcnt);
    end
    @(posedge clk);
    if (p_vld) hold[p_id] = p_data;
    p_vld = 0;
    if (win >= 0) begin
      if (ew == 4'b0) begin
        p_vld = 1; p_id = (win == 1); p_data = mmem[ea[13:2]];
      end else for (int b = 0; b < 4; b++)
        if (ew[b]) mmem[ea[13:2]][8*b +: 8] = ed[8*b +: 8];
    end
    if (r0 && r1) begin
      if (mcnt < (1 << CW) - 1) mcnt++;
`ifdef SRAM_ARB_RR_EN
      rr_next = (win == 0) ? 1 : 0;
`endif
    end
    #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  vec_t tbl [14];
  logic q_r0, q_r1;
  logic [3:0] q_w0, q_w1;
  logic [31:0] q_a0, q_a1, q_d0, q_d1;
  bit held0, held1;

  initial begin
    reset = 1'b0; preload = 1;
    m0_req = 0; m0_wen = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_wen = 0; m1_addr = 0; m1_wdata = 0;
    model_reset();
    mmem[16] = DE;
    repeat (2) @(posedge clk);
    #1 preload = 0;
    m0_req = 1; m1_req = 1; m1_addr = 32'h80;
    #3;
    chk("rst_m0_gnt", m0_gnt, 0);
    chk("rst_m1_gnt", m1_gnt, 0);
    chk("rst_sram_en", sram_en, 0);
    chk("rst_sram_addr", sram_addr, 0);
    chk("rst_m0_rvalid", m0_rvalid, 0);
    chk("rst_m1_rvalid", m1_rvalid, 0);
    chk("rst_m0_rdata", m0_rdata, 0);
    chk("rst_m1_rdata", m1_rdata, 0);
    chk("rst_cnt", conflict_cnt, 0);
    m0_req = 0; m1_req = 0; m1_addr = 0;
    @(posedge clk);
    #1 reset = 1'b1;

    // Directed vectors: {m0 req,addr,wen,wdata, m1 req,addr,wen,wdata, gnt0,gnt1,rv0,rv1, sram_addr, rdata0,rdata1}
    tbl[0]  = mk(1, 32'h40, 4'h0, 0,  0, 0, 4'h0, 0,       1, 0, 0, 0, 32'h40, 0,  0);
    tbl[1]  = mk(0, 0, 4'h0, 0,       0, 0, 4'h0, 0,       0, 0, 1, 0, 0,      DE, 0);
    tbl[2]  = mk(0, 0, 4'h0, 0,       0, 0, 4'h0, 0,       0, 0, 0, 0, 0,      DE, 0);
    tbl[3]  = mk(0, 0, 4'h0, 0,       1, 32'h80, 4'hF, CC, 0, 1, 0, 0, 32'h80, DE, 0);
    tbl[4]  = mk(0, 0, 4'h0, 0,       1, 32'h80, 4'h0, 0,  0, 1, 0, 0, 32'h80, DE, 0);
    tbl[5]  = mk(0, 0, 4'h0, 0,       0, 0, 4'h0, 0,       0, 0, 0, 1, 0,      DE, CC);
    tbl[6]  = mk(1, 32'h40, 4'h0, 0,  1, 32'h80, 4'h0, 0,  0, 1, 0, 0, 32'h80, DE, CC);
`ifdef SRAM_ARB_RR_EN
    tbl[7]  = mk(1, 32'h40, 4'h0, 0,  1, 32'h80, 4'h0, 0,  1, 0, 0, 1, 32'h40, DE, CC);
    tbl[8]  = mk(1, 32'h40, 4'h0, 0,  1, 32'h80, 4'h0, 0,  0, 1, 1, 0, 32'h80, DE, CC);
`else
    tbl[7]  = mk(1, 32'h40, 4'h0, 0,  1, 32'h80, 4'h0, 0,  0, 1, 0, 1, 32'h80, DE, CC);
    tbl[8]  = mk(1, 32'h40, 4'h0, 0,  1, 32'h80, 4'h0, 0,  0, 1, 0, 1, 32'h80, DE, CC);
`endif
    tbl[9]  = mk(0, 0, 4'h0, 0,       0, 0, 4'h0, 0,       0, 0, 0, 1, 0,      DE, CC);
    tbl[10] = mk(1, 32'h80, 4'h0, 0,  0, 0, 4'h0, 0,       1, 0, 0, 0, 32'h80, DE, CC);
    tbl[11] = mk(0, 0, 4'h0, 0,       1, 32'h40, 4'h0, 0,  0, 1, 1, 0, 32'h40, CC, CC);
    tbl[12] = mk(1, 32'h40, 4'h0, 0,  0, 0, 4'h0, 0,       1, 0, 0, 1, 32'h40, CC, DE);
    tbl[13] = mk(0, 0, 4'h0, 0,       0, 0, 4'h0, 0,       0, 0, 1, 0, 0,      DE, DE);

    for (int i = 0; i < 14; i++) begin
      step(tbl[i].r0, tbl[i].w0, tbl[i].a0, tbl[i].d0, tbl[i].r1, tbl[i].w1, tbl[i].a1, tbl[i].d1, 1);
      chk($sformatf("tbl%0d_gnt0", i), s_g0, tbl[i].g0);
      chk($sformatf("tbl%0d_gnt1", i), s_g1, tbl[i].g1);
      chk($sformatf("tbl%0d_rvalid0", i), s_v0, tbl[i].v0);
      chk($sformatf("tbl%0d_rvalid1", i), s_v1, tbl[i].v1);
      chk($sformatf("tbl%0d_sram_addr", i), s_sa, tbl[i].sa);
      chk($sformatf("tbl%0d_rdata0", i), s_rd0, tbl[i].rd0);
      chk($sformatf("tbl%0d_rdata1", i), s_rd1, tbl[i].rd1);
    end
    chk("conflict_cnt_after_3", conflict_cnt, 3);

    // Random traffic; a denied master keeps its request stable until granted.
    held0 = 0; held1 = 0;
    for (int i = 0; i < 600; i++) begin
      if (!held0) begin
        q_r0 = ($urandom_range(0, 3) != 0);
        q_w0 = $urandom_range(0, 1) ? 4'($urandom_range(1, 15)) : 4'h0;
        q_a0 = 32'($urandom_range(0, 63)) << 2;
        q_d0 = $urandom;
      end
      if (!held1) begin
        q_r1 = ($urandom_range(0, 3) != 0);
        q_w1 = $urandom_range(0, 1) ? 4'($urandom_range(1, 15)) : 4'h0;
        q_a1 = 32'($urandom_range(0, 63)) << 2;
        q_d1 = $urandom;
      end
      step(q_r0, q_w0, q_a0, q_d0, q_r1, q_w1, q_a1, q_d1, 1);
      held0 = q_r0 && !s_g0;
      held1 = q_r1 && !s_g1;
    end

    // Reset asserted while a read is outstanding.
    step(1, 4'h0, 32'h40, 0, 0, 4'h0, 0, 0, 1);
    reset = 1'b0;
    m0_req = 1; m1_req = 1;
    #3;
    chk("rstp_m0_gnt", m0_gnt, 0);
    chk("rstp_m1_gnt", m1_gnt, 0);
    chk("rstp_sram_en", sram_en, 0);
    chk("rstp_m0_rvalid", m0_rvalid, 0);
    chk("rstp_m0_rdata", m0_rdata, 0);
    chk("rstp_cnt", conflict_cnt, 0);
    @(posedge clk);
    #1 reset = 1'b1;
    model_reset();
    step(0, 4'h0, 0, 0, 0, 4'h0, 0, 0, 1);
    chk("rstp_post_rvalid0", s_v0, 0);
    chk("rstp_post_rvalid1", s_v1, 0);
    chk("rstp_post_rdata0", s_rd0, 0);
    chk("rstp_post_rdata1", s_rd1, 0);

    // Counter saturation.
    for (int i = 0; i < 65534; i++)
      step(1, 4'h0, 32'h40, 0, 1, 4'h0, 32'h80, 0, 0);
    chk("sat_pre", conflict_cnt, 65534);
    step(1, 4'h0, 32'h40, 0, 1, 4'h0, 32'h80, 0, 1);
    chk("sat_hit", conflict_cnt, 65535);
    repeat (3) step(1, 4'h0, 32'h40, 0, 1, 4'h0, 32'h80, 0, 1);
    chk("sat_hold", conflict_cnt, 65535);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
